skeletonize_param: RTL
======================

// Module: skeletonize_param
// PURPOSE
//   Parametrised laser-line skeletoniser for the scanner video path. Thresholds each valid
//   pixel of a line and bridges short dark gaps. Finds the longest bright run per line and
//   reports its centre at half-pixel resolution, with run length and a found flag.
//   Sits between the camera/threshold front end and the triangulation/depth stage.
// PARAMETERS
//   PX_W       8    pixel width; px_in is PX_W bits
//   THRESH     128  pixel is bright iff px_in >= THRESH (unsigned)
//   COL_W      11   column index width; column counter saturates at 2^COL_W-1
//   ROW_W      11   row index width; wraps modulo 2^ROW_W
//   NOISE_TOL  3    max consecutive dark pixels bridged inside a run
//   MIN_RUN    2    runs shorter than this are ignored
// PORTS
//   clk         in   1        system clock
//   reset_n     in   1        asynchronous reset, active low
//   fvh_in      in   3        {field, vsync, hsync}; rising [1] = new frame, rising [0] = new line
//   dv_in       in   1        pixel valid; px_in is sampled only when 1
//   px_in       in   PX_W     pixel value
//   current_row out  ROW_W    row index of the line being reported
//   midpoint2   out  COL_W+1  start+end of the winning run (centre x2; LSB = half pixel)
//   run_len     out  COL_W    winning run length, end-start+1, bridged gaps included
//   found       out  1        1 = a run >= MIN_RUN existed in the reported line
//   row_done    out  1        one-cycle strobe; outputs above are valid from this cycle
// BEHAVIOUR
//   - Reset (async, reset_n=0): every output is 0. last_fvh=0, state=DARK, col=0,
//     in_line=0, row counter=0.
//   - Edges: last_fvh registers fvh_in every cycle.
//     NF = fvh_in[1]&~last_fvh[1]. NL = fvh_in[0]&~last_fvh[0].
//   - NF (priority over NL in the same cycle): discard the open line with no row_done.
//     Set row=0, in_line=0 and clear the scan state. A simultaneous NL is then treated as
//     the first line start.
//   - NL with in_line=1: close the line and report it; row_done=1 in the next cycle.
//     Report current_row = row index of the closed line. Then row++ and restart the scan.
//   - NL with in_line=0: start scanning only; in_line=1; no row_done; row index stays 0.
//   - row_done is high for exactly one cycle. The report outputs hold until the next report.
//   - Pixel step (no NF/NL, dv_in=1): b = (px_in >= THRESH). Column = col, then col++
//     (col saturates). dv_in=0 cycles freeze col and the FSM.
//   - FSM states:
//     DARK: b -> RUN, start=end=col.
//     RUN:  b -> end=col. ~b -> GAP, gap=1.
//     GAP:  b -> RUN, end=col.
//           ~b and gap<NOISE_TOL -> gap++.
//           ~b and gap==NOISE_TOL -> close the run, go to DARK.
//   - Close run: len = end-start+1. Candidate iff len >= MIN_RUN and len > best_len
//     (strict, so the earliest equal-length run wins). Candidate sets best_len=len and
//     best_sum=start+end (COL_W+1 bits, no overflow).
//   - At NL report time, a run still open in RUN or GAP is closed first, using the same
//     rules with end = last bright column. Trailing dark pixels are never counted.
//   - Report: found=(best_len!=0). midpoint2=best_sum and run_len=best_len when found,
//     else both are 0.
//   - Reset mid-line: all state is lost; the next line after reset is not reported
//     (in_line=0).
// TESTING
//   1. Row of 10 px: dark, then bright at cols 3..7 -> row_done; found=1, midpoint2=10,
//      run_len=5, current_row=0.
//   2. Bright at 2..4, dark at 5..7 (3, bridged), bright at 8..9 -> run_len=8, midpoint2=11.
//      Same with dark at 5..8 (4 dark) -> two runs, len 3 and 1; found=1, midpoint2=6,
//      run_len=3.
//   3. Two equal runs, 1..3 and 10..12 -> midpoint2=4 (first wins). All-dark line -> found=0,
//      midpoint2=0, run_len=0.
//   4. Line whose bright run 20..25 runs to the line end, then NL -> run_len=6,
//      midpoint2=45. dv_in toggling every other cycle gives identical results.
//   5. Frame with 3 lines, then NF mid-line -> row_done exactly twice (rows 0 and 1). The
//      next frame's first reported row is 0. NF and NL in the same cycle -> no report.
//   6. Drop reset_n mid-run -> outputs go to 0 immediately. After release, the first NL
//      gives no row_done and the second NL reports row 0.

Source files
------------

// File: rtl/skeletonize_param_if.sv
// ----------------------------------------------------------------------------
// skeletonize_param_if
//   Video-in / line-report bundle for the laser-line skeletoniser.
//   Source side (master) drives the pixel stream and sync bits. Skeletoniser
//   side (slave) returns the per-line report.
//
//   fvh_in      3        {field, vsync, hsync}
//   dv_in       1        pixel valid
//   px_in       PX_W     pixel value
//   current_row ROW_W    row index of the reported line
//   midpoint2   COL_W+1  start+end of the winning run (centre x2)
//   run_len     COL_W    winning run length
//   found       1        a qualifying run existed
//   row_done    1        one-cycle report strobe
// ----------------------------------------------------------------------------
interface skeletonize_param_if #(
    parameter int PX_W  = 8,
    parameter int COL_W = 11,
    parameter int ROW_W = 11
);
    logic [2:0]       fvh_in;
    logic             dv_in;
    logic [PX_W-1:0]  px_in;
    logic [ROW_W-1:0] current_row;
    logic [COL_W:0]   midpoint2;
    logic [COL_W-1:0] run_len;
    logic             found;
    logic             row_done;

    modport master (
        output fvh_in, dv_in, px_in,
        input  current_row, midpoint2, run_len, found, row_done
    );

    modport slave (
        input  fvh_in, dv_in, px_in,
        output current_row, midpoint2, run_len, found, row_done
    );
endinterface

// File: rtl/skeletonize_param.sv
// ----------------------------------------------------------------------------
// skeletonize_param
//   Laser-line skeletoniser. Thresholds each valid pixel, bridges short dark
//   gaps inside a bright run, and reports per line the longest run's centre
//   (x2, half-pixel resolution), its length and a found flag.
//
//   clk      in   system clock
//   reset_n  in   asynchronous reset, active low
//   vid      slave side of skeletonize_param_if (pixel stream in, report out)
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_DARK  | no run open; waiting for a bright pixel
//   ST_RUN   | run open, last valid pixel was bright
//   ST_GAP   | run open, inside a dark gap of gap_q pixels (not yet closed)
// ----------------------------------------------------------------------------
module skeletonize_param #(
    parameter int PX_W      = 8,
    parameter int THRESH    = 128,
    parameter int COL_W     = 11,
    parameter int ROW_W     = 11,
    parameter int NOISE_TOL = 3,
    parameter int MIN_RUN   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    skeletonize_param_if.slave   vid
);

    localparam int GAP_W = (NOISE_TOL < 1) ? 1 : $clog2(NOISE_TOL + 1);

    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(NOISE_TOL);
    localparam logic [COL_W-1:0] MIN_LEN = COL_W'(MIN_RUN);
    localparam logic [COL_W-1:0] COL_MAX = '1;
    localparam logic [PX_W-1:0]  THR     = PX_W'(THRESH);

    typedef enum logic [1:0] {
        ST_DARK = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       last_fvh_q;
    logic [COL_W-1:0] col_q, col_d;
    logic [COL_W-1:0] run_start_q, run_start_d;
    logic [COL_W-1:0] run_end_q, run_end_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [COL_W-1:0] best_len_q, best_len_d;
    logic [COL_W:0]   best_sum_q, best_sum_d;
    logic             in_line_q, in_line_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic [ROW_W-1:0] cur_row_q, cur_row_d;
    logic [COL_W:0]   mid2_q, mid2_d;
    logic [COL_W-1:0] run_len_q, run_len_d;
    logic             found_q, found_d;
    logic             row_done_q, row_done_d;

    logic             new_frame;
    logic             new_line;
    logic             bright;
    logic             run_open;
    logic [COL_W-1:0] open_len;
    logic [COL_W:0]   open_sum;
    logic             open_cand;
    logic [COL_W-1:0] final_len;
    logic [COL_W:0]   final_sum;

    // The field bit travels with the sync bits but this stage has no use for it.
    logic             unused_field;
    assign unused_field = last_fvh_q[2];

    assign new_frame = vid.fvh_in[1] & ~last_fvh_q[1];
    assign new_line  = vid.fvh_in[0] & ~last_fvh_q[0];
    assign bright    = (vid.px_in >= THR);

    // Candidate evaluation for the currently open run. Used both when a gap
    // grows too long and when the line ends with a run still open.
    assign run_open  = (state_q != ST_DARK);
    assign open_len  = run_end_q - run_start_q + COL_W'(1);
    assign open_sum  = {1'b0, run_start_q} + {1'b0, run_end_q};
    assign open_cand = (open_len >= MIN_LEN) && (open_len > best_len_q);

    assign final_len = (run_open && open_cand) ? open_len : best_len_q;
    assign final_sum = (run_open && open_cand) ? open_sum : best_sum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_DARK;
            last_fvh_q  <= '0;
            col_q       <= '0;
            run_start_q <= '0;
            run_end_q   <= '0;
            gap_q       <= '0;
            best_len_q  <= '0;
            best_sum_q  <= '0;
            in_line_q   <= 1'b0;
            row_q       <= '0;
            cur_row_q   <= '0;
            mid2_q      <= '0;
            run_len_q   <= '0;
            found_q     <= 1'b0;
            row_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_fvh_q  <= vid.fvh_in;
            col_q       <= col_d;
            run_start_q <= run_start_d;
            run_end_q   <= run_end_d;
            gap_q       <= gap_d;
            best_len_q  <= best_len_d;
            best_sum_q  <= best_sum_d;
            in_line_q   <= in_line_d;
            row_q       <= row_d;
            cur_row_q   <= cur_row_d;
            mid2_q      <= mid2_d;
            run_len_q   <= run_len_d;
            found_q     <= found_d;
            row_done_q  <= row_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        run_start_d = run_start_q;
        run_end_d   = run_end_q;
        gap_d       = gap_q;
        best_len_d  = best_len_q;
        best_sum_d  = best_sum_q;
        in_line_d   = in_line_q;
        row_d       = row_q;
        cur_row_d   = cur_row_q;
        mid2_d      = mid2_q;
        run_len_d   = run_len_q;
        found_d     = found_q;
        row_done_d  = 1'b0;

        if (new_frame) begin
            // Open line is dropped silently; a coincident hsync edge opens line 0.
            row_d       = '0;
            in_line_d   = new_line;
            state_d     = ST_DARK;
            col_d       = '0;
            run_start_d = '0;
            run_end_d   = '0;
            gap_d       = '0;
            best_len_d  = '0;
            best_sum_d  = '0;
        end else if (new_line) begin
            if (in_line_q) begin
                row_done_d = 1'b1;
                cur_row_d  = row_q;
                found_d    = (final_len != '0);
                mid2_d     = (final_len != '0) ? final_sum : '0;
                run_len_d  = final_len;
                row_d      = row_q + ROW_W'(1);
            end
            in_line_d   = 1'b1;
            state_d     = ST_DARK;
            col_d       = '0;
            run_start_d = '0;
            run_end_d   = '0;
            gap_d       = '0;
            best_len_d  = '0;
            best_sum_d  = '0;
        end else if (vid.dv_in) begin
            if (col_q != COL_MAX) begin
                col_d = col_q + COL_W'(1);
            end
            unique case (state_q)
                ST_DARK: begin
                    if (bright) begin
                        state_d     = ST_RUN;
                        run_start_d = col_q;
                        run_end_d   = col_q;
                    end
                end
                ST_RUN: begin
                    if (bright) begin
                        run_end_d = col_q;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = GAP_W'(1);
                    end
                end
                ST_GAP: begin
                    if (bright) begin
                        state_d   = ST_RUN;
                        run_end_d = col_q;
                    end else if (gap_q < GAP_MAX) begin
                        gap_d = gap_q + GAP_W'(1);
                    end else begin
                        // Gap exceeded tolerance: run ends at the last bright column.
                        state_d = ST_DARK;
                        if (open_cand) begin
                            best_len_d = open_len;
                            best_sum_d = open_sum;
                        end
                    end
                end
                default: begin
                    state_d = ST_DARK;
                end
            endcase
        end
    end

    assign vid.current_row = cur_row_q;
    assign vid.midpoint2   = mid2_q;
    assign vid.run_len     = run_len_q;
    assign vid.found       = found_q;
    assign vid.row_done    = row_done_q;

endmodule
